// File: rtl/btn_debounce_pulse_if.sv
// Button conditioner bundle: raw active-low pin in, debounced level, event pulses,
// press counter and busy flag out.
interface btn_debounce_pulse_if;
  logic       i_btn_n;
  logic       o_btn;
  logic       o_press;
  logic       o_release;
  logic       o_long;
  logic [7:0] o_press_cnt;
  logic       o_busy;

  modport master (
    output i_btn_n,
    input  o_btn, o_press, o_release, o_long, o_press_cnt, o_busy
  );

  modport slave (
    input  i_btn_n,
    output o_btn, o_press, o_release, o_long, o_press_cnt, o_busy
  );
endinterface

// File: rtl/btn_debounce_pulse.sv
// Push-button conditioner: 2-flop synchroniser, stability-timer debounce FSM,
// press/release pulses, wrapping press counter. Long-press pulse under BTN_LONG_PRESS_EN.
module btn_debounce_pulse #(
  parameter int unsigned DEBOUNCE_CYCLES = 100000,
  parameter int unsigned LONG_CYCLES     = 16000000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  btn_debounce_pulse_if.slave bus
);

  localparam int unsigned DW = 24;
  localparam int unsigned CW = 8;
  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  state_t        state;
  logic [1:0]    sync;
  logic          s;
  logic [DW-1:0] dcnt;
  logic          btn_q;
  logic          press_q;
  logic          release_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;

`ifdef BTN_LONG_PRESS_EN
  localparam int unsigned HW = 26;
  localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] HMAX  = HW'(LONG_CYCLES);
  logic [HW-1:0] hcnt;
  logic          long_q;
`endif

  // Synchroniser resets to "released" so a held button is re-qualified after reset
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) sync <= 2'b11;
    else          sync <= {sync[0], bus.i_btn_n};
  end

  assign s = ~sync[1];

  // Debounce FSM; pulses default low so each asserts for exactly one cycle
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      dcnt      <= '0;
      btn_q     <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
      hcnt      <= '0;
      long_q    <= 1'b0;
`endif
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_LONG_PRESS_EN
      long_q    <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (s) begin
            state  <= PRESS_WAIT;
            dcnt   <= '0;
            busy_q <= 1'b1;
          end
        end
        PRESS_WAIT: begin
          if (!s) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (dcnt == DLAST) begin
            state   <= PRESSED;
            busy_q  <= 1'b0;
            btn_q   <= 1'b1;
            press_q <= 1'b1;
            cnt_q   <= cnt_q + CW'(1);
`ifdef BTN_LONG_PRESS_EN
            hcnt    <= '0;
`endif
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        PRESSED: begin
          if (!s) begin
            state  <= RELEASE_WAIT;
            dcnt   <= '0;
            busy_q <= 1'b1;
          end else begin
`ifdef BTN_LONG_PRESS_EN
            // Saturating at LONG_CYCLES keeps the long pulse to one per press
            if (hcnt == HLAST) long_q <= 1'b1;
            if (hcnt < HMAX)   hcnt   <= hcnt + HW'(1);
`endif
          end
        end
        RELEASE_WAIT: begin
          if (s) begin
            state  <= PRESSED;
            busy_q <= 1'b0;
          end else if (dcnt == DLAST) begin
            state     <= IDLE;
            busy_q    <= 1'b0;
            btn_q     <= 1'b0;
            release_q <= 1'b1;
          end else begin
            dcnt <= dcnt + DW'(1);
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_btn       = btn_q;
  assign bus.o_press     = press_q;
  assign bus.o_release   = release_q;
  assign bus.o_press_cnt = cnt_q;
  assign bus.o_busy      = busy_q;
`ifdef BTN_LONG_PRESS_EN
  assign bus.o_long      = long_q;
`else
  assign bus.o_long      = 1'b0;
`endif

endmodule
